// File: rtl/ooe_div_array.sv
// Out-of-order iterative divider array with in-order retirement.
// Units compute by repeated subtraction; a reorder buffer restores order.
module ooe_div_array #(
  parameter int W         = 8,
  parameter int N_DIV     = 4,
  parameter int ROB_DEPTH = 8,
  localparam int AW = $clog2(ROB_DEPTH),
  localparam int PW = AW + 1,
  localparam int UW = (N_DIV > 1) ? $clog2(N_DIV) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_dividend,
  input  logic [W-1:0]  in_divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_quotient,
  output logic [W-1:0]  out_remainder,
  output logic          out_dbz,
  output logic [PW-1:0] rob_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } st_e;

  st_e          st_q   [N_DIV];
  st_e          st_d   [N_DIV];
  logic [W-1:0] ur_q   [N_DIV];
  logic [W-1:0] ur_d   [N_DIV];
  logic [W-1:0] uy_q   [N_DIV];
  logic [W-1:0] uy_d   [N_DIV];
  logic [W-1:0] uq_q   [N_DIV];
  logic [W-1:0] uq_d   [N_DIV];
  logic         udbz_q [N_DIV];
  logic         udbz_d [N_DIV];
  logic [AW-1:0] utag_q [N_DIV];
  logic [AW-1:0] utag_d [N_DIV];

  logic [W-1:0] rq_q   [ROB_DEPTH];
  logic [W-1:0] rr_q   [ROB_DEPTH];
  logic         rdbz_q [ROB_DEPTH];
  logic         rrdy_q [ROB_DEPTH];

  logic [PW-1:0] wp_q, wp_d;
  logic [PW-1:0] rp_q, rp_d;
  logic          init_q;

  logic          any_idle, any_done;
  logic [UW-1:0] disp_idx, wb_idx;
  logic          accept, retire;
  logic [AW-1:0] head, wb_tag;

  always_comb begin
    any_idle = 1'b0;
    any_done = 1'b0;
    disp_idx = '0;
    wb_idx   = '0;
    for (int i = N_DIV - 1; i >= 0; i--) begin
      if (st_q[i] == IDLE) begin
        any_idle = 1'b1;
        disp_idx = UW'(i);
      end
      if (st_q[i] == DONE) begin
        any_done = 1'b1;
        wb_idx   = UW'(i);
      end
    end
  end

  assign rob_count = wp_q - rp_q;
  assign head      = rp_q[AW-1:0];
  assign wb_tag    = utag_q[wb_idx];
  assign in_ready  = init_q && (rob_count != PW'(ROB_DEPTH)) && any_idle;
  assign accept    = in_valid && in_ready;
  assign out_valid = rrdy_q[head];
  assign retire    = out_valid && out_ready;

  assign out_quotient  = rq_q[head];
  assign out_remainder = rr_q[head];
  assign out_dbz       = rdbz_q[head];

  assign wp_d = wp_q + {{AW{1'b0}}, accept};
  assign rp_d = rp_q + {{AW{1'b0}}, retire};

  always_comb begin
    for (int i = 0; i < N_DIV; i++) begin
      st_d[i]   = st_q[i];
      ur_d[i]   = ur_q[i];
      uy_d[i]   = uy_q[i];
      uq_d[i]   = uq_q[i];
      udbz_d[i] = udbz_q[i];
      utag_d[i] = utag_q[i];
      unique case (st_q[i])
        IDLE: begin
          if (accept && disp_idx == UW'(i)) begin
            st_d[i]   = CALC;
            ur_d[i]   = in_dividend;
            uy_d[i]   = in_divisor;
            uq_d[i]   = '0;
            udbz_d[i] = 1'b0;
            utag_d[i] = wp_q[AW-1:0];
          end
        end
        CALC: begin
          if (uy_q[i] == '0) begin
            st_d[i]   = DONE;
            uq_d[i]   = '1;
            udbz_d[i] = 1'b1;
          end else if (ur_q[i] >= uy_q[i]) begin
            ur_d[i] = ur_q[i] - uy_q[i];
            uq_d[i] = uq_q[i] + W'(1);
          end else begin
            st_d[i] = DONE;
          end
        end
        DONE: begin
          if (any_done && wb_idx == UW'(i)) st_d[i] = IDLE;
        end
        default: st_d[i] = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_DIV; i++) begin
        st_q[i]   <= IDLE;
        ur_q[i]   <= '0;
        uy_q[i]   <= '0;
        uq_q[i]   <= '0;
        udbz_q[i] <= 1'b0;
        utag_q[i] <= '0;
      end
      wp_q   <= '0;
      rp_q   <= '0;
      init_q <= 1'b0;
    end else begin
      for (int i = 0; i < N_DIV; i++) begin
        st_q[i]   <= st_d[i];
        ur_q[i]   <= ur_d[i];
        uy_q[i]   <= uy_d[i];
        uq_q[i]   <= uq_d[i];
        udbz_q[i] <= udbz_d[i];
        utag_q[i] <= utag_d[i];
      end
      wp_q   <= wp_d;
      rp_q   <= rp_d;
      init_q <= 1'b1;
    end
  end

  // Writeback is issued after the retire clear; the two never target one entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int e = 0; e < ROB_DEPTH; e++) begin
        rq_q[e]   <= '0;
        rr_q[e]   <= '0;
        rdbz_q[e] <= 1'b0;
        rrdy_q[e] <= 1'b0;
      end
    end else begin
      if (retire) rrdy_q[head] <= 1'b0;
      if (accept) rrdy_q[wp_q[AW-1:0]] <= 1'b0;
      if (any_done) begin
        rq_q[wb_tag]   <= uq_q[wb_idx];
        rr_q[wb_tag]   <= ur_q[wb_idx];
        rdbz_q[wb_tag] <= udbz_q[wb_idx];
        rrdy_q[wb_tag] <= 1'b1;
      end
    end
  end

endmodule

// File: doc/ooe_div_array.md
OOE_DIV_ARRAY -- requirements
Module: ooe_div_array

Interface
REQ-001 SHALL have parameter W, default 8: operand, quotient and remainder width in bits (W >= 2).
REQ-002 SHALL have parameter N_DIV, default 4: number of iterative divider units (1..16).
REQ-003 SHALL have parameter ROB_DEPTH, default 8: reorder-buffer entries (power of two, >= 2).
REQ-004 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port in_valid, input, 1: a dividend/divisor pair is offered.
REQ-007 SHALL have port in_ready, output, 1: the pair is accepted on this edge if in_valid is also high.
REQ-008 SHALL have port in_dividend, input, W: unsigned dividend.
REQ-009 SHALL have port in_divisor, input, W: unsigned divisor.
REQ-010 SHALL have port out_valid, output, 1: the oldest result is presented.
REQ-011 SHALL have port out_ready, input, 1: the consumer takes the result on this edge if out_valid is also high.
REQ-012 SHALL have port out_quotient, output, W.
REQ-013 SHALL have port out_remainder, output, W.
REQ-014 SHALL have port out_dbz, output, 1: the result came from a divide by zero.
REQ-015 SHALL have port rob_count, output, clog2(ROB_DEPTH)+1: number of occupied ROB entries.

Function
REQ-016 Accept: SHALL accept when in_valid && in_ready; in_ready = (rob_count != ROB_DEPTH) && (any unit IDLE); same-cycle retire SHALL NOT raise in_ready.
REQ-017 Dispatch: on accept, SHALL load the lowest-index IDLE unit with dividend, divisor and tag = write pointer mod ROB_DEPTH, and allocate that ROB entry (ready=0).
REQ-018 Unit FSM: SHALL have states IDLE -> CALC (on dispatch) -> DONE (on finish) -> IDLE (on writeback grant); no other transitions.
REQ-019 CALC: SHALL on the first cycle with divisor==0 go DONE with Q=all-ones, R=dividend, dbz=1.
REQ-020 CALC: otherwise each cycle SHALL do R>=Y ? (R-=Y, Q+=1) : go DONE; the unit spends exactly Q+1 cycles in CALC.
REQ-021 Writeback: one unit per cycle; SHALL grant the lowest-index DONE unit; Q, R, dbz SHALL be written into the ROB entry at its tag, entry ready=1, unit -> IDLE on the same edge.
REQ-022 A granted unit SHALL NOT be dispatchable until the cycle after writeback.
REQ-023 Retire: out_valid SHALL equal the ready bit of the head entry; out_* SHALL come from the head entry; on out_valid && out_ready the head SHALL advance and its ready bit clear.
REQ-024 Output SHALL hold out_* stable while out_valid && !out_ready; results SHALL leave strictly in acceptance order.
REQ-025 Latency, no contention: for an accept at edge E with quotient k, out_valid SHALL first be high after edge E+k+2 (divide by zero: E+2).
REQ-026 Pointers SHALL be clog2(ROB_DEPTH)+1 bits and wrap modulo 2*ROB_DEPTH; rob_count = wp - rp.
REQ-027 Simultaneous accept and retire SHALL leave rob_count unchanged; simultaneous writeback to entry X and retire of head entry H != X SHALL both take effect.
REQ-028 in_dividend and in_divisor SHALL only be sampled on the accept edge; they are don't-care otherwise.

Reset
REQ-029 rst_n low SHALL immediately force: all units IDLE, rob_count=0, all ready bits 0, pointers 0, in_ready=0 until the first rising clk after release, out_valid=0, out_quotient=0, out_remainder=0, out_dbz=0.
REQ-030 Assertion of rst_n mid-operation SHALL discard all in-flight and buffered results; none SHALL appear after release.
REQ-031 After release, in_ready SHALL be 1 (all units idle, ROB empty).

Verification
REQ-032 Single op 13/4, out_ready=1 -> out_valid after edge E+5; Q=3, R=1, dbz=0; rob_count 1 -> 0.
REQ-033 Order: accept 200/1, then 9/3, 5/7 back-to-back (N_DIV=4) -> units finish out of order, outputs in order (200,0), (3,0), (0,5).
REQ-034 Dbz: 77/0 -> Q=0xFF, R=77, dbz=1 after E+2 (W=8).
REQ-035 Full: out_ready=0, 8 pairs of 1/1 -> in_ready=0 at rob_count=8; one retire -> rob_count=7 the next cycle, in_ready=1.
REQ-036 Units busy: 4 pairs of 255/1 in flight -> in_ready=0 with rob_count=4; first writeback -> unit 0 re-dispatchable the cycle after.
REQ-037 Reset during traffic -> outputs 0, rob_count=0; 10/5 after release -> Q=2, R=0 only.
